mem_unit: RTL and testbench
===========================

// Module: mem_unit
// PURPOSE
//  4096x16 main memory responder; the far end of the AR address path.
//  Accepts one read or write request at the address held in AR.
//  Reads return on Q_MEM to the common bus; write data comes from the bus.
//  Programmable wait states model slow memory; READY marks completion to control.
// PARAMETERS
//  ADDR_W    12  address width (memory depth = 2**ADDR_W words)
//  DATA_W    16  word width
//  WAIT_CYC  1   extra wait cycles before the access commits (0..15)
// PORTS
//  CLK    in   1       system clock; all state changes on posedge
//  RST_N  in   1       reset, asynchronous, active-low
//  IN_AR  in   ADDR_W  address from AR
//  IN     in   DATA_W  write data from the common bus
//  READ   in   1       read request, level, sampled only in IDLE
//  WRITE  in   1       write request, level, sampled only in IDLE
//  Q_MEM  out  DATA_W  read data; holds its value until the next read completes
//  READY  out  1       one-cycle pulse when an access completes
//  BUSY   out  1       high from request accept until READY, inclusive
//  ERR    out  1       one-cycle pulse: READ and WRITE both high in IDLE
// BEHAVIOUR
//  Reset (async, RST_N=0)
//   - Outputs: Q_MEM=0, READY=0, BUSY=0, ERR=0.
//   - Internal: state=IDLE, cnt=0.
//   - Memory contents are not cleared.
//  FSM states: IDLE, WAIT, DONE
//  IDLE
//   - READ^WRITE=1 at edge k: latch IN_AR, IN and the op; BUSY<=1; cnt<=WAIT_CYC.
//   - If WAIT_CYC=0: commit the access at edge k and go to DONE.
//   - Otherwise go to WAIT.
//   - READ&WRITE=1: ERR<=1 for one cycle, no access, stay in IDLE.
//   - Neither request: stay in IDLE.
//  WAIT
//   - cnt>1: cnt<=cnt-1.
//   - cnt==1: commit the access and go to DONE.
//  Commit
//   - Read: Q_MEM<=mem[addr].
//   - Write: mem[addr]<=data; Q_MEM unchanged.
//   - Entering DONE also sets READY<=1.
//  DONE
//   - READY and BUSY are high for this one cycle.
//   - Next edge: READY<=0, BUSY<=0, state IDLE.
//  Latency: request sampled at edge k -> READY high after edge k+WAIT_CYC, for 1 cycle.
//  Minimum spacing between accepts is WAIT_CYC+2 cycles.
//  Requests during WAIT/DONE are ignored, not queued.
//  A request still high on return to IDLE starts a new access; the controller must drop it.
//  Latched address and data are used for the commit; IN_AR/IN may change after accept.
//  Address is fully decoded: 0x000..0xFFF are valid, with no wrap or alias.
//  Read-after-write to the same address returns the new word.
//  Reset while in WAIT aborts the access; memory is untouched.
//  A write already committed on the edge into DONE stays written.
// STRUCTURE
//  Shared package mano_pkg:
//   - ADDR_W, DATA_W constants
//   - 2-bit state encodings IDLE=0, WAIT=1, DONE=2
//  Sub-module mem_array: single-port synchronous RAM with we, addr, wdata, rdata.
//  mem_unit holds the FSM, the wait counter and the request latches.
// TESTING
//  1 Reset: RST_N=0 mid-WAIT -> Q_MEM=0, READY=0, BUSY=0 immediately.
//    The pending write to 0x010 is absent on a later read.
//  2 WAIT_CYC=1: WRITE 0x1234 @0x005, then READ @0x005 -> Q_MEM=0x1234.
//    READY pulses 1 cycle after each accept edge.
//  3 WAIT_CYC=0: READ @0xFFF after writing 0xBEEF there.
//    -> Q_MEM=0xBEEF and READY in the cycle right after the accept edge.
//  4 READ=WRITE=1 in IDLE -> ERR=1 for exactly 1 cycle, BUSY=0, memory unchanged.
//  5 Change IN_AR 0x005->0x006 during WAIT of a read -> data from 0x005 returned.
//    A second READ pulse during WAIT is ignored (one READY only).
//  6 Hold READ high -> accesses repeat every WAIT_CYC+2 cycles.
//    Q_MEM is stable between reads; a write leaves Q_MEM at its old value.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared sizing and FSM encodings for the main-memory responder.
package mano_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM; the read register doubles as the held read result.
module mem_array
  import mano_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_we,
  input  logic  i_re,
  input  addr_t i_addr,
  input  word_t i_wdata,
  output word_t o_rdata
);

  word_t r_mem [0:(1<<ADDR_W)-1];

  // Array itself is never reset; contents survive RST_N.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_unit.sv
// Main memory responder: request latch, wait-state counter and access FSM.
//   state | meaning
//   IDLE  | waiting for exactly one of READ/WRITE
//   WAIT  | request latched, counting down wait states
//   DONE  | access committed, READY/BUSY high for one cycle
module mem_unit
  import mano_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  addr_t i_in_ar,
  input  word_t i_in,
  input  logic  i_read,
  input  logic  i_write,
  output word_t o_q_mem,
  output logic  o_ready,
  output logic  o_busy,
  output logic  o_err
);

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  addr_t      r_addr;
  word_t      r_data;
  logic       r_wr;
  logic       r_ready;
  logic       r_busy;
  logic       r_err;

  logic  w_idle;
  logic  w_accept;
  logic  w_clash;
  logic  w_commit;
  logic  w_op_wr;
  addr_t w_addr;
  word_t w_wdata;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & (i_read ^ i_write);
  assign w_clash  = w_idle & i_read & i_write;

  // With no wait states the access commits on the accept edge, so the live inputs feed the RAM.
  assign w_commit = (w_accept && (WAIT_CYC == 0)) ||
                    ((r_state == ST_WAIT) && (r_cnt == 4'd1));
  assign w_op_wr  = w_idle ? i_write : r_wr;
  assign w_addr   = w_idle ? i_in_ar : r_addr;
  assign w_wdata  = w_idle ? i_in    : r_data;

  mem_array u_mem_array (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_commit & w_op_wr),
    .i_re    (w_commit & ~w_op_wr),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (o_q_mem)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_clash;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr <= i_in_ar;
            r_data <= i_in;
            r_wr   <= i_write;
            r_busy <= 1'b1;
            r_cnt  <= 4'(WAIT_CYC);
            if (WAIT_CYC == 0) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt > 4'd1) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
            r_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_err   = r_err;

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: one instance with one wait state, one with none.
module tb_mem_unit;

  logic        clk;
  logic        rst_n;

  logic        rd1, wr1, rd0, wr0;
  logic [11:0] ar1, ar0;
  logic [15:0] in1, in0;
  logic [15:0] q1, q0;
  logic        rdy1, busy1, err1, rdy0, busy0, err0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_unit #(.WAIT_CYC(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_ar(ar1), .i_in(in1),
    .i_read(rd1), .i_write(wr1), .o_q_mem(q1), .o_ready(rdy1),
    .o_busy(busy1), .o_err(err1)
  );

  mem_unit #(.WAIT_CYC(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_ar(ar0), .i_in(in0),
    .i_read(rd0), .i_write(wr0), .o_q_mem(q0), .o_ready(rdy0),
    .o_busy(busy0), .o_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [15:0] data;
    logic [15:0] exp_q;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Single-pulse access; inputs are scrambled after the accept edge to prove latching.
  task automatic access(input bit sel, input bit wr, input logic [11:0] addr,
                        input logic [15:0] data, input int exp_lat,
                        input logic [15:0] exp_q, input string tag);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    @(negedge clk);
    if (sel) begin rd1 = !wr; wr1 = wr; ar1 = addr; in1 = data; end
    else     begin rd0 = !wr; wr0 = wr; ar0 = addr; in0 = data; end
    @(posedge clk);
    @(negedge clk);
    if (sel) begin rd1 = 0; wr1 = 0; ar1 = addr + 12'd1; in1 = ~data; end
    else     begin rd0 = 0; wr0 = 0; ar0 = addr + 12'd1; in0 = ~data; end
    for (int i = 1; i <= 8 && !got; i++) begin
      if (i > 1) @(negedge clk);
      if (sel ? rdy1 : rdy0) begin
        got = 1;
        lat = i;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy@ready"}, 32'(sel ? busy1 : busy0), 32'd1);
    check({tag, " q"}, 32'(sel ? q1 : q0), 32'(exp_q));
    @(negedge clk);
    check({tag, " ready drop"}, 32'(sel ? rdy1 : rdy0), 32'd0);
    check({tag, " busy drop"}, 32'(sel ? busy1 : busy0), 32'd0);
  endtask

  initial begin
    int          n_rdy;
    logic [12:0] pat;

    vecs[0]  = '{1'b1, 12'h005, 16'h1234, 16'h0000};
    vecs[1]  = '{1'b0, 12'h005, 16'h0000, 16'h1234};
    vecs[2]  = '{1'b1, 12'h000, 16'h0A0A, 16'h1234};
    vecs[3]  = '{1'b1, 12'hFFF, 16'h5555, 16'h1234};
    vecs[4]  = '{1'b0, 12'h000, 16'h0000, 16'h0A0A};
    vecs[5]  = '{1'b0, 12'hFFF, 16'h0000, 16'h5555};
    vecs[6]  = '{1'b1, 12'h005, 16'hCAFE, 16'h5555};
    vecs[7]  = '{1'b0, 12'h005, 16'h0000, 16'hCAFE};
    vecs[8]  = '{1'b1, 12'h800, 16'h8001, 16'hCAFE};
    vecs[9]  = '{1'b0, 12'h800, 16'h0000, 16'h8001};
    vecs[10] = '{1'b0, 12'h000, 16'h0000, 16'h0A0A};
    vecs[11] = '{1'b1, 12'h006, 16'h0066, 16'h0A0A};

    rd1 = 0; wr1 = 0; ar1 = '0; in1 = '0;
    rd0 = 0; wr0 = 0; ar0 = '0; in0 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset q1", 32'(q1), 32'h0);
    check("reset ready1", 32'(rdy1), 32'h0);
    check("reset busy1", 32'(busy1), 32'h0);
    check("reset err1", 32'(err1), 32'h0);
    check("reset q0", 32'(q0), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      access(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].data, 2, vecs[i].exp_q,
             $sformatf("vec%0d", i));

    // Address moves to 0x006 and READ re-pulses while the read of 0x005 is in WAIT.
    @(negedge clk);
    rd1 = 1; ar1 = 12'h005;
    @(posedge clk);
    @(negedge clk);
    ar1 = 12'h006;
    n_rdy = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) @(negedge clk);
      if (rdy1) n_rdy++;
      if (i == 2) rd1 = 0;
    end
    check("wait repulse ready count", 32'(n_rdy), 32'd1);
    check("wait addr change q", 32'(q1), 32'hCAFE);

    // READ and WRITE together: error pulse only.
    @(negedge clk);
    rd1 = 1; wr1 = 1; ar1 = 12'h000; in1 = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    check("clash err", 32'(err1), 32'd1);
    check("clash busy", 32'(busy1), 32'd0);
    rd1 = 0; wr1 = 0;
    @(negedge clk);
    check("clash err drop", 32'(err1), 32'd0);
    access(1'b1, 1'b0, 12'h000, 16'h0000, 2, 16'h0A0A, "clash readback");

    // Held READ: READY every WAIT_CYC+2 = 3 cycles.
    @(negedge clk);
    rd1 = 1; ar1 = 12'h005;
    pat = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      pat[i] = rdy1;
      if (rdy1) check($sformatf("held read q @%0d", i), 32'(q1), 32'hCAFE);
    end
    rd1 = 0;
    check("held read ready pattern", 32'(pat), 32'h924);
    repeat (2) @(negedge clk);

    access(1'b0, 1'b1, 12'hFFF, 16'hBEEF, 1, 16'h0000, "w0 write");
    access(1'b0, 1'b0, 12'hFFF, 16'h0000, 1, 16'hBEEF, "w0 read");

    // Reset mid-WAIT aborts a pending write.
    access(1'b1, 1'b1, 12'h010, 16'h1111, 2, 16'hCAFE, "pre-abort write");
    @(negedge clk);
    wr1 = 1; ar1 = 12'h010; in1 = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    wr1 = 0;
    check("abort busy in wait", 32'(busy1), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort q", 32'(q1), 32'h0);
    check("abort ready", 32'(rdy1), 32'h0);
    check("abort busy", 32'(busy1), 32'h0);
    check("abort q0", 32'(q0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 12'h010, 16'h0000, 2, 16'h1111, "abort readback");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
